fc_class_argmax: RTL

//  Downstream sequencer/consumer of the single-neuron FC stage. It runs the FC once per output class:

---
 rtl/fc_class_argmax.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fc_class_argmax.sv
// Sequencer for the single-neuron FC stage. It runs one FC evaluation per class and
// reports the index and score of the highest result, with a watchdog on each evaluation.
module fc_class_argmax #(
    parameter int N_CLASS = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    localparam int IDX_W  = $clog2(N_CLASS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_fc_start,
    output logic [IDX_W-1:0]  o_class_sel,
    input  logic [DATA_W-1:0] i_fc_output,
    input  logic              i_fc_finished,
    output logic [IDX_W-1:0]  o_class,
    output logic [DATA_W-1:0] o_score,
    output logic              o_valid,
    output logic              o_error
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLASS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_ABORT  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [IDX_W-1:0]          r_idx;
    logic [TMR_W-1:0]          r_timer;
    logic signed [DATA_W-1:0]  r_best;
    logic [IDX_W-1:0]          r_best_idx;
    logic [IDX_W-1:0]          r_class;
    logic signed [DATA_W-1:0]  r_score;

    logic signed [DATA_W-1:0]  w_result;
    logic                      w_fin;
    logic                      w_take;
    logic                      w_last;

    // Strict signed compare so that a tie keeps the earlier (lower) class index.
    function automatic logic beats(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b);
        return a > b;
    endfunction

    assign w_result = $signed(i_fc_output);
    assign w_fin    = (r_state == S_WAIT) && i_fc_finished;
    assign w_last   = (r_idx == IDX_LAST);
    // Class 0 always seeds the running max, so an all-negative run never reports zero.
    assign w_take   = (r_idx == '0) || beats(w_result, r_best);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_fc_finished) begin
                    w_next = w_last ? S_DONE : S_LAUNCH;
                end else if (r_timer == TMR_LAST) begin
                    w_next = S_ABORT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx      <= '0;
            r_timer    <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_class    <= '0;
            r_score    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) r_idx <= '0;
                end
                S_LAUNCH: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (w_fin) begin
                        if (w_take) begin
                            r_best     <= w_result;
                            r_best_idx <= r_idx;
                        end
                        // Publish on the way into DONE, folding in the last class's result.
                        if (w_last) begin
                            r_class <= w_take ? r_idx : r_best_idx;
                            r_score <= w_take ? w_result : r_best;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_DONE, S_ABORT: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_fc_start  = (r_state == S_LAUNCH);
    assign o_valid     = (r_state == S_DONE);
    assign o_error     = (r_state == S_ABORT);
    assign o_class_sel = r_idx;
    assign o_class     = r_class;
    assign o_score     = r_score;

endmodule
